// File: rtl/adc_serial_responder.sv
// adc_serial_responder
// Device side of the CS/SCL/SDA serial ADC read link. The block keeps the most
// recent conversion result. On each CS-low frame it drives one start-marker bit
// on SDA and then shifts out the sample, MSB first.
//
// Ports
//   CLK, ASYNC_RST  : system clock; asynchronous active-low reset
//   SCL, CS         : serial clock and active-low chip select from the initiator
//                     (both asynchronous to CLK)
//   SAMPLE_IN/VALID : new conversion result and its one-cycle load strobe
//   SDA_OUT, SDA_OE : serial data value and its drive enable (the tri-state
//                     buffer sits in the wrapper)
//   BUSY            : high while a frame is in progress (any state except IDLE)
//   FRAME_DONE      : one-cycle pulse when the last data bit has completed
//   ABORT           : one-cycle pulse when CS rises before the frame completes
//   TEST_STATE      : current FSM state code, zero-extended to 8 bits
module adc_serial_responder #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        START_VALUE = 1'b1
) (
    input  logic                  CLK,
    input  logic                  ASYNC_RST,
    input  logic                  SCL,
    input  logic                  CS,
    input  logic [DATA_WIDTH-1:0] SAMPLE_IN,
    input  logic                  SAMPLE_VALID,
    output logic                  SDA_OUT,
    output logic                  SDA_OE,
    output logic                  BUSY,
    output logic                  FRAME_DONE,
    output logic                  ABORT,
    output logic [7:0]            TEST_STATE
);

    localparam int unsigned CNT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // ------------------------------------------------------------------
    // Synchronizers and edge detection (lines idle high)
    // ------------------------------------------------------------------
    logic [SYNC_N-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_N-1:0] cs_sync_q, cs_sync_d;
    logic              scl_hist_q, scl_hist_d;
    logic              cs_hist_q, cs_hist_d;
    logic              scl_s, cs_s;
    logic              scl_fall_c, cs_fall_c, cs_rise_c;

    assign scl_s = scl_sync_q[SYNC_N-1];
    assign cs_s  = cs_sync_q[SYNC_N-1];

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_N-2:0], SCL};
        cs_sync_d  = {cs_sync_q[SYNC_N-2:0], CS};
        scl_hist_d = scl_s;
        cs_hist_d  = cs_s;
    end

    assign scl_fall_c = scl_hist_q & ~scl_s;
    assign cs_fall_c  = cs_hist_q & ~cs_s;
    assign cs_rise_c  = ~cs_hist_q & cs_s;

    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            scl_sync_q <= '1;
            cs_sync_q  <= '1;
            scl_hist_q <= 1'b1;
            cs_hist_q  <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            cs_sync_q  <= cs_sync_d;
            scl_hist_q <= scl_hist_d;
            cs_hist_q  <= cs_hist_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM, data path and registered outputs
    // ------------------------------------------------------------------
    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  sda_out_q, sda_out_d;
    logic                  sda_oe_q, sda_oe_d;
    logic                  busy_q, busy_d;
    logic                  frame_done_q, frame_done_d;
    logic                  abort_q, abort_d;

    // Next state plus outputs; outputs are decoded from the next state so that
    // they change in the same cycle as the state register.
    always_comb begin
        state_d      = state_q;
        hold_d       = SAMPLE_VALID ? SAMPLE_IN : hold_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;
        abort_d      = 1'b0;
        sda_out_d    = 1'b0;
        sda_oe_d     = 1'b0;
        busy_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall_c) begin
                    state_d = ST_ARMED;
                    // Same-cycle strobe bypasses the holding register
                    shift_d = SAMPLE_VALID ? SAMPLE_IN : hold_q;
                    cnt_d   = '0;
                end
            end
            ST_ARMED: begin
                if (cs_rise_c) begin
                    state_d = ST_IDLE;
                    abort_d = 1'b1;
                end else if (scl_fall_c) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cs_rise_c) begin
                    state_d = ST_IDLE;
                    abort_d = 1'b1;
                end else if (scl_fall_c) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end
            end
            ST_DATA: begin
                // CS rise has priority over a coincident SCL fall
                if (cs_rise_c) begin
                    state_d = ST_IDLE;
                    abort_d = 1'b1;
                end else if (scl_fall_c) begin
                    if (cnt_q == LAST_BIT) begin
                        state_d      = ST_DONE;
                        frame_done_d = 1'b1;
                    end else begin
                        shift_d = shift_q << 1;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (cs_rise_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_ARMED, ST_START: begin
                sda_oe_d  = 1'b1;
                sda_out_d = START_VALUE;
            end
            ST_DATA: begin
                sda_oe_d  = 1'b1;
                sda_out_d = shift_d[DATA_WIDTH-1];
            end
            default: begin
                sda_oe_d  = 1'b0;
                sda_out_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            shift_q      <= '0;
            cnt_q        <= '0;
            sda_out_q    <= 1'b0;
            sda_oe_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            sda_out_q    <= sda_out_d;
            sda_oe_q     <= sda_oe_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            abort_q      <= abort_d;
        end
    end

    assign SDA_OUT    = sda_out_q;
    assign SDA_OE     = sda_oe_q;
    assign BUSY       = busy_q;
    assign FRAME_DONE = frame_done_q;
    assign ABORT      = abort_q;
    assign TEST_STATE = 8'(state_q);

endmodule

// File: tb/tb_adc_serial_responder.sv
// Testbench for adc_serial_responder: table of frame vectors with a scoreboard
// queue of expected SDA bits, plus hand-written reset sequences.
module tb_adc_serial_responder;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl;
    logic       cs;
    logic [7:0] sin;
    logic       sv;
    logic       sda_out, sda_oe, busy, frame_done, abort_o;
    logic [7:0] test_state;

    int n_vec = 0;
    int n_err = 0;
    int done_hi = 0;
    int abort_hi = 0;
    logic exp_q[$];

    typedef struct {
        logic       do_pre;
        logic [7:0] pre;
        logic       do_byp;
        logic [7:0] byp;
        logic       do_mid;
        logic [7:0] mid;
        int         periods;
        int         abort_after;
        logic [7:0] exp_word;
        int         exp_done;
        int         exp_abort;
    } vec_t;

    vec_t vecs[10];

    adc_serial_responder dut (
        .CLK          (clk),
        .ASYNC_RST    (rst_n),
        .SCL          (scl),
        .CS           (cs),
        .SAMPLE_IN    (sin),
        .SAMPLE_VALID (sv),
        .SDA_OUT      (sda_out),
        .SDA_OE       (sda_oe),
        .BUSY         (busy),
        .FRAME_DONE   (frame_done),
        .ABORT        (abort_o),
        .TEST_STATE   (test_state)
    );

    always #5 clk = ~clk;

    // Count high cycles of each pulse output; a correct pulse is exactly one.
    always @(negedge clk) begin
        if (frame_done === 1'b1) done_hi++;
        if (abort_o === 1'b1) abort_hi++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        int   d0;
        int   a0;
        logic e;
        if (v.do_pre) begin
            @(negedge clk); sin = v.pre; sv = 1'b1;
            @(negedge clk); sv = 1'b0;
            repeat (2) @(negedge clk);
        end
        exp_q.delete();
        exp_q.push_back(1'b1);
        for (int b = 7; b >= 0; b--) exp_q.push_back(v.exp_word[b]);
        d0 = done_hi;
        a0 = abort_hi;

        @(negedge clk); cs = 1'b0;
        if (v.do_byp) begin
            // Strobe lands on the cycle the CS fall is detected
            @(negedge clk);
            @(negedge clk); sin = v.byp; sv = 1'b1;
            @(negedge clk); sv = 1'b0;
            repeat (3) @(negedge clk);
        end else begin
            repeat (6) @(negedge clk);
        end
        check($sformatf("v%0d armed state", idx), 32'(test_state), 32'd1);
        check($sformatf("v%0d armed oe", idx), 32'(sda_oe), 32'd1);
        check($sformatf("v%0d armed sda", idx), 32'(sda_out), 32'd1);
        check($sformatf("v%0d armed busy", idx), 32'(busy), 32'd1);

        for (int p = 1; p <= v.periods; p++) begin
            scl = 1'b0;
            if (v.do_mid && p == 5) begin
                sin = v.mid; sv = 1'b1;
                @(negedge clk); sv = 1'b0;
                repeat (HALF - 1) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            if (p <= 9) begin
                e = exp_q.pop_front();
                check($sformatf("v%0d sda rise%0d", idx, p), 32'(sda_out), 32'(e));
                check($sformatf("v%0d oe rise%0d", idx, p), 32'(sda_oe), 32'd1);
            end else begin
                check($sformatf("v%0d released oe p%0d", idx, p), 32'(sda_oe), 32'd0);
                check($sformatf("v%0d done state p%0d", idx, p), 32'(test_state), 32'd4);
            end
            scl = 1'b1;
            repeat (HALF) @(negedge clk);
            if (p == v.abort_after) break;
        end

        if (v.abort_after > 0) begin
            cs = 1'b1;
            repeat (3) @(negedge clk);
            check($sformatf("v%0d abort oe", idx), 32'(sda_oe), 32'd0);
            check($sformatf("v%0d abort state", idx), 32'(test_state), 32'd0);
            check($sformatf("v%0d abort busy", idx), 32'(busy), 32'd0);
            exp_q.delete();
        end else begin
            check($sformatf("v%0d end state", idx), 32'(test_state), 32'd4);
            check($sformatf("v%0d end oe", idx), 32'(sda_oe), 32'd0);
            check($sformatf("v%0d end busy", idx), 32'(busy), 32'd1);
            check($sformatf("v%0d queue left", idx), 32'(exp_q.size()), 32'd0);
            cs = 1'b1;
            repeat (4) @(negedge clk);
            check($sformatf("v%0d idle state", idx), 32'(test_state), 32'd0);
            check($sformatf("v%0d idle busy", idx), 32'(busy), 32'd0);
        end
        repeat (3) @(negedge clk);
        check($sformatf("v%0d frame_done cycles", idx), 32'(done_hi - d0), 32'(v.exp_done));
        check($sformatf("v%0d abort cycles", idx), 32'(abort_hi - a0), 32'(v.exp_abort));
    endtask

    initial begin
        vec_t after_rst;

        vecs[0] = '{1'b1, 8'h55, 1'b0, 8'h00, 1'b0, 8'h00, 10, 0, 8'h55, 1, 0};
        vecs[1] = '{1'b1, 8'h00, 1'b1, 8'hA3, 1'b0, 8'h00, 10, 0, 8'hA3, 1, 0};
        vecs[2] = '{1'b1, 8'hF0, 1'b0, 8'h00, 1'b1, 8'h0F, 10, 0, 8'hF0, 1, 0};
        vecs[3] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 10, 0, 8'h0F, 1, 0};
        vecs[4] = '{1'b1, 8'hC3, 1'b0, 8'h00, 1'b0, 8'h00, 10, 5, 8'hC3, 0, 1};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 10, 0, 8'hC3, 1, 0};
        vecs[6] = '{1'b1, 8'h96, 1'b0, 8'h00, 1'b0, 8'h00, 14, 0, 8'h96, 1, 0};
        vecs[7] = '{1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 8'h00, 10, 0, 8'h01, 1, 0};
        vecs[8] = '{1'b1, 8'h80, 1'b0, 8'h00, 1'b0, 8'h00, 10, 0, 8'h80, 1, 0};
        vecs[9] = '{1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 8'h00, 10, 1, 8'hFF, 0, 1};
        after_rst = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 10, 0, 8'h00, 1, 0};

        // Reset held with CS low and SCL toggling
        rst_n = 1'b0; cs = 1'b0; scl = 1'b1; sin = 8'h00; sv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            repeat (3) @(negedge clk); scl = 1'b0;
            repeat (3) @(negedge clk); scl = 1'b1;
        end
        check("reset sda_out", 32'(sda_out), 32'd0);
        check("reset sda_oe", 32'(sda_oe), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset frame_done", 32'(frame_done), 32'd0);
        check("reset abort", 32'(abort_o), 32'd0);
        check("reset state", 32'(test_state), 32'd0);
        cs = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("post-reset state", 32'(test_state), 32'd0);
        check("post-reset busy", 32'(busy), 32'd0);

        for (int i = 0; i < 10; i++) run_frame(vecs[i], i);

        // Reset asserted mid-frame clears everything without a clock edge
        @(negedge clk); sin = 8'h5A; sv = 1'b1;
        @(negedge clk); sv = 1'b0; cs = 1'b0;
        repeat (6) @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            scl = 1'b0; repeat (HALF) @(negedge clk);
            scl = 1'b1; repeat (HALF) @(negedge clk);
        end
        scl = 1'b0;
        repeat (HALF) @(negedge clk);
        check("midframe pre-reset oe", 32'(sda_oe), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("midframe reset oe", 32'(sda_oe), 32'd0);
        check("midframe reset state", 32'(test_state), 32'd0);
        check("midframe reset busy", 32'(busy), 32'd0);
        @(negedge clk); scl = 1'b1; cs = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("after midframe reset state", 32'(test_state), 32'd0);
        // Holding register was cleared by reset, so the next frame returns 0
        run_frame(after_rst, 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/adc_serial_responder.md
# adc_serial_responder

Synthesizable responder for the serial ADC link: the device-side end of the CS/SCL/SDA read protocol that the system wrapper drives as initiator. It sits behind the sample source, holds the latest 8-bit conversion result, and on each CS-low frame shifts out a start marker bit followed by the sample on SDA. It is used both as an on-chip loopback target for the wrapper and as the FPGA-side emulation of the ADC.

## Interface
Parameters:
- DATA_WIDTH, 8, sample width in bits shifted per frame
- SYNC_STAGES, 2, synchronizer flops on SCL and CS (minimum 2)
- START_VALUE, 1'b1, level driven on SDA during the start marker bit

Ports:
- CLK  input  1  system clock; all logic on rising edge
- ASYNC_RST  input  1  asynchronous, active-low reset
- SCL  input  1  serial clock from initiator, asynchronous to CLK
- CS  input  1  chip select from initiator, active-low, asynchronous
- SAMPLE_IN  input  DATA_WIDTH  new conversion result
- SAMPLE_VALID  input  1  one-cycle strobe; loads SAMPLE_IN into holding register
- SDA_OUT  output  1  serial data value; tri-state buffer lives in wrapper
- SDA_OE  output  1  1 = drive SDA_OUT onto SDA, 0 = release (hi-Z)
- BUSY  output  1  high from CS-low detection until return to IDLE
- FRAME_DONE  output  1  one-cycle pulse after last data bit completes
- ABORT  output  1  one-cycle pulse when CS rises before frame completes
- TEST_STATE  output  8  current FSM state code, zero-extended

## Operation
- SCL and CS pass through SYNC_STAGES flops; edge detect on synchronized copies plus one history flop. Reset value of synchronizer/history flops: 1 (idle-high lines).
- Holding register: loaded from SAMPLE_IN on any cycle with SAMPLE_VALID=1, regardless of state; reset 0.
- Shift register: loaded from holding register on CS-fall detection. If SAMPLE_VALID is high in that same cycle, SAMPLE_IN is loaded directly (bypass).
- FSM (TEST_STATE codes):
  - IDLE (0): SDA_OE=0, BUSY=0. CS fall -> ARMED.
  - ARMED (1): SDA_OE=1, SDA_OUT=START_VALUE. First SCL fall -> START.
  - START (2): SDA_OUT=START_VALUE held for one full SCL period. Next SCL fall -> DATA, SDA_OUT=shift[MSB], bit counter=0.
  - DATA (3): each SCL fall shifts left one bit, counter increments; SDA_OUT always shift[MSB]. SCL fall with counter=DATA_WIDTH-1 -> DONE.
  - DONE (4): SDA_OE=0, FRAME_DONE pulses on entry cycle. Further SCL edges ignored. CS rise -> IDLE.
- CS rise detected in ARMED, START or DATA: SDA_OE=0 same cycle, ABORT pulses, -> IDLE. No FRAME_DONE.
- CS rise and SCL fall detected in the same cycle: CS wins (abort/idle).
- SCL edges while CS high: ignored.
- Reset asserted mid-frame: all state cleared immediately, SDA_OE=0 asynchronously.
- Bit counter width: clog2(DATA_WIDTH); no wrap is reachable because DONE stops counting.

## Timing
- Reset values: SDA_OUT=0, SDA_OE=0, BUSY=0, FRAME_DONE=0, ABORT=0, TEST_STATE=0.
- Pin-to-action latency: SYNC_STAGES+1 CLK cycles from SCL/CS pin edge to registered output change (3 cycles at default).
- SDA changes only after SCL falling edge; initiator samples on SCL rising edge. SCL high and low phases must each be >= SYNC_STAGES+2 CLK cycles.
- Frame length: 1 start bit + DATA_WIDTH data bits = 9 SCL periods at default; DONE entered on the 10th SCL fall.
- FRAME_DONE and ABORT are registered, exactly one CLK wide.

## Test plan
- Reset: ASYNC_RST=0 with CS=0 and SCL toggling -> all outputs 0, TEST_STATE=0; release -> stays IDLE until next CS fall.
- Basic frame: SAMPLE_IN=8'h55 strobed, CS low, 10 SCL periods (half-period 8 CLK) -> SDA sampled on SCL rises reads 1,0,1,0,1,0,1,0,1; FRAME_DONE one pulse; SDA_OE=0 after.
- Bypass: SAMPLE_VALID with 8'hA3 in same cycle as CS-fall detection, holding previously 8'h00 -> frame shifts 1 then 1,0,1,0,0,0,1,1.
- Update during frame: frame of 8'hF0 with SAMPLE_VALID 8'h0F strobed mid-DATA -> current frame returns F0, next frame returns 0F.
- Abort: CS rises after 4th data bit -> SDA_OE=0 within 3 CLK, ABORT one pulse, no FRAME_DONE, TEST_STATE=0; next full frame correct.
- Extra clocks: 14 SCL periods with CS low -> SDA released after bit 8, TEST_STATE stays 4 until CS rise.
